// File: rtl/myo_spi_scheduler.sv
// Round-robin SPI master for myocontrol motor boards: one ss_n frame of FRAME_WORDS
// full-duplex words per enabled motor per sweep, TX from a register-file read port.
module myo_spi_scheduler #(
  parameter int unsigned NUM_MOTORS  = 9,
  parameter int unsigned WORD_WIDTH  = 16,
  parameter int unsigned FRAME_WORDS = 4,
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned SS_SETUP    = 4,
  localparam int unsigned MW = (NUM_MOTORS  > 1) ? $clog2(NUM_MOTORS)  : 1,
  localparam int unsigned WB = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [NUM_MOTORS-1:0] motor_mask,
  input  logic [31:0]           update_period,
  input  logic                  power_sense_n,
  output logic [MW-1:0]         tx_rd_motor,
  output logic [WB-1:0]         tx_rd_word,
  input  logic [WORD_WIDTH-1:0] tx_rd_data,
  output logic                  rx_valid,
  output logic [MW-1:0]         rx_motor,
  output logic [WB-1:0]         rx_word,
  output logic [WORD_WIDTH-1:0] rx_data,
  output logic                  sweep_done,
  output logic                  busy,
  output logic                  power_fault,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso,
  output logic [NUM_MOTORS-1:0] ss_n
);

  localparam int unsigned SW = $clog2(SS_SETUP + 1);
  localparam int unsigned DW = $clog2(CLK_DIV + 1);
  localparam int unsigned BW = $clog2(WORD_WIDTH + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_SELECT, S_LOAD, S_SETUP, S_SHIFT, S_HOLD, S_DONE, S_WAIT
  } state_t;

  state_t                r_state;
  logic [NUM_MOTORS-1:0] r_mask;
  logic [MW:0]           r_idx;
  logic [MW-1:0]         r_motor;
  logic [WB-1:0]         r_txw;
  logic [WB-1:0]         r_word;
  logic [SW-1:0]         r_cnt;
  logic [DW-1:0]         r_div;
  logic [BW-1:0]         r_bit;
  logic [31:0]           r_period;
  logic [WORD_WIDTH-1:0] r_tx;
  logic [WORD_WIDTH-1:0] r_rx;
  logic [NUM_MOTORS-1:0] r_ss_n;
  logic                  r_sck;
  logic                  r_busy;
  logic                  r_power_fault;
  logic                  r_sweep_done;
  logic                  r_rx_valid;
  logic [MW-1:0]         r_rx_motor;
  logic [WB-1:0]         r_rx_word;
  logic [WORD_WIDTH-1:0] r_rx_data;

  logic                  w_found;
  logic [MW-1:0]         w_next;
  logic [WB-1:0]         w_txw_next;
  logic                  w_period_hit;

  always_comb begin
    w_found = 1'b0;
    w_next  = '0;
    for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
      if (!w_found && r_mask[i] && (i >= 32'(r_idx))) begin
        w_found = 1'b1;
        w_next  = MW'(i);
      end
    end
  end

  assign w_txw_next   = (r_txw == WB'(FRAME_WORDS - 1)) ? r_txw : r_txw + WB'(1);
  assign w_period_hit = ({1'b0, r_period} + 33'd1) >= {1'b0, update_period};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_mask        <= '0;
      r_idx         <= '0;
      r_motor       <= '0;
      r_txw         <= '0;
      r_word        <= '0;
      r_cnt         <= '0;
      r_div         <= '0;
      r_bit         <= '0;
      r_period      <= '0;
      r_tx          <= '0;
      r_rx          <= '0;
      r_ss_n        <= '1;
      r_sck         <= 1'b0;
      r_busy        <= 1'b0;
      r_power_fault <= 1'b0;
      r_sweep_done  <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_rx_motor    <= '0;
      r_rx_word     <= '0;
      r_rx_data     <= '0;
    end else begin
      r_rx_valid   <= 1'b0;
      r_sweep_done <= 1'b0;
      if (r_state == S_START) r_period <= 32'd1;
      else if (r_period != '1) r_period <= r_period + 32'd1;

      case (r_state)
        S_IDLE: if (enable) begin
          r_state <= S_START;
          r_busy  <= 1'b1;
        end
        S_START: begin
          r_mask  <= motor_mask;
          r_idx   <= '0;
          r_state <= S_SELECT;
        end
        // A latched fault also blocks further frames until enable is dropped.
        S_SELECT: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (power_sense_n || r_power_fault) begin
            r_power_fault <= 1'b1;
            r_sweep_done  <= 1'b1;
            r_state       <= S_DONE;
          end else if (!w_found) begin
            r_sweep_done <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_motor <= w_next;
            r_txw   <= '0;
            r_word  <= '0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_ss_n[r_motor] <= 1'b0;
          r_cnt           <= '0;
          r_state         <= S_SETUP;
        end
        S_SETUP: begin
          if (power_sense_n) r_power_fault <= 1'b1;
          if (r_cnt == '0) begin
            r_tx  <= tx_rd_data;
            r_txw <= w_txw_next;
          end
          if (r_cnt == SW'(SS_SETUP - 1)) begin
            r_div   <= '0;
            r_bit   <= '0;
            r_state <= S_SHIFT;
          end else begin
            r_cnt <= r_cnt + SW'(1);
          end
        end
        // Word completion (rx strobe + next prefetched TX word) happens on the falling
        // sck of the last bit, so words run back-to-back with no extra state.
        S_SHIFT: begin
          if (power_sense_n) r_power_fault <= 1'b1;
          if (r_div == DW'(CLK_DIV - 1)) begin
            r_div <= '0;
            r_sck <= ~r_sck;
            if (!r_sck) begin
              r_rx <= (r_rx << 1) | WORD_WIDTH'(miso);
            end else if (r_bit == BW'(WORD_WIDTH - 1)) begin
              r_bit      <= '0;
              r_rx_valid <= 1'b1;
              r_rx_data  <= r_rx;
              r_rx_motor <= r_motor;
              r_rx_word  <= r_word;
              if (r_word == WB'(FRAME_WORDS - 1)) begin
                r_tx    <= '0;
                r_ss_n  <= '1;
                r_cnt   <= '0;
                r_state <= S_HOLD;
              end else begin
                r_tx   <= tx_rd_data;
                r_txw  <= w_txw_next;
                r_word <= r_word + WB'(1);
              end
            end else begin
              r_bit <= r_bit + BW'(1);
              r_tx  <= r_tx << 1;
            end
          end else begin
            r_div <= r_div + DW'(1);
          end
        end
        S_HOLD: begin
          if (r_cnt == SW'(SS_SETUP - 1)) begin
            r_idx   <= {1'b0, r_motor} + (MW+1)'(1);
            r_state <= S_SELECT;
          end else begin
            r_cnt <= r_cnt + SW'(1);
          end
        end
        S_DONE: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_period_hit) begin
            r_state <= S_START;
          end else begin
            r_state <= S_WAIT;
            r_busy  <= 1'b0;
          end
        end
        S_WAIT: begin
          if (!enable) begin
            r_state <= S_IDLE;
          end else if (w_period_hit) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      if (!enable) r_power_fault <= 1'b0;
    end
  end

  assign tx_rd_motor = r_motor;
  assign tx_rd_word  = r_txw;
  assign rx_valid    = r_rx_valid;
  assign rx_motor    = r_rx_motor;
  assign rx_word     = r_rx_word;
  assign rx_data     = r_rx_data;
  assign sweep_done  = r_sweep_done;
  assign busy        = r_busy;
  assign power_fault = r_power_fault;
  assign sck         = r_sck;
  assign mosi        = r_tx[WORD_WIDTH-1];
  assign ss_n        = r_ss_n;

endmodule
